// File: rtl/relay_shift_driver.sv
// relay_shift_driver
//   Serialises a WIDTH-bit relay image into an external shift/storage
//   register chain. The image is synchronised into the clk domain. It is
//   shifted out MSB first only after it has been seen stable and found to
//   differ from the last image sent. A forced first transfer after reset is
//   also sent.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   relay_word  relay image, asynchronous to clk
//   sr_clk      serial clock to the shift register
//   sr_data     serial data, MSB first
//   sr_latch    storage-register latch pulse, active high
//   sr_oe_n     shift-register output enable, active low
//   busy        high while a transfer is in progress
//   xfer_count  number of completed transfers (wraps)
module relay_shift_driver #(
  parameter int WIDTH   = 48,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] relay_word,
  output logic             sr_clk,
  output logic             sr_data,
  output logic             sr_latch,
  output logic             sr_oe_n,
  output logic             busy,
  output logic [15:0]      xfer_count
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] SHIFT_LO = 3'd2;
  localparam logic [2:0] SHIFT_HI = 3'd3;
  localparam logic [2:0] LATCH    = 3'd4;

  localparam int         BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [WIDTH-1:0] sync1, sync2, sync3;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shift_q;
  logic [2:0]       valid;
  logic             pending;
  logic [2:0]       state, next_state;
  logic [7:0]       div_cnt;
  logic [BW-1:0]    bit_cnt;

  logic stable;
  logic req;
  logic phase_done;

  // The reset-cleared sync chain compares equal before the real word has
  // reached sync3. valid tracks that fill so that the forced post-reset
  // transfer sends the actual word and not the cleared zeros.
  assign stable     = (sync2 == sync3);
  assign req        = valid[2] && stable && (pending || (sync2 != shadow));
  assign phase_done = (div_cnt == DIV_LAST);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (req) next_state = LOAD;
      LOAD:     next_state = SHIFT_LO;
      SHIFT_LO: if (phase_done) next_state = SHIFT_HI;
      SHIFT_HI: if (phase_done) next_state = (bit_cnt == '0) ? LATCH : SHIFT_LO;
      LATCH:    if (phase_done) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      sync3      <= '0;
      valid      <= '0;
      shadow     <= '0;
      shift_q    <= '0;
      pending    <= 1'b1;
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sr_clk     <= 1'b0;
      sr_data    <= 1'b0;
      sr_latch   <= 1'b0;
      sr_oe_n    <= 1'b1;
      busy       <= 1'b0;
      xfer_count <= '0;
    end else begin
      sync1 <= relay_word;
      sync2 <= sync1;
      sync3 <= sync2;
      valid <= {valid[1:0], 1'b1};

      state    <= next_state;
      // Outputs are decoded from next_state so they change on the same edge
      // as the state register.
      sr_clk   <= (next_state == SHIFT_HI);
      sr_latch <= (next_state == LATCH);
      busy     <= (next_state != IDLE);

      if ((state == SHIFT_LO) || (state == SHIFT_HI) || (state == LATCH))
        div_cnt <= phase_done ? '0 : div_cnt + 8'd1;
      else
        div_cnt <= '0;

      case (state)
        LOAD: begin
          shadow  <= sync2;
          shift_q <= sync2;
          bit_cnt <= BW'(WIDTH - 1);
          sr_data <= sync2[WIDTH-1];
          pending <= 1'b0;
        end
        SHIFT_HI: begin
          if (phase_done && (bit_cnt != '0)) begin
            shift_q <= shift_q << 1;
            bit_cnt <= bit_cnt - BW'(1);
            sr_data <= shift_q[WIDTH-2];
          end
        end
        LATCH: begin
          if (phase_done) begin
            sr_oe_n    <= 1'b0;
            xfer_count <= xfer_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_relay_shift_driver.sv
// tb_relay_shift_driver
//   Drives two instances (CLK_DIV=4 and CLK_DIV=1) from the same relay word
//   and reset. Expected words are logged when stimulus is applied. Each
//   instance's monitor reconstructs the serial word at every latch pulse and
//   compares it with the next logged word.
module tb_relay_shift_driver;

  logic        clk;
  logic        reset;
  logic [47:0] word;

  logic [1:0]  sr_clk_w, sr_data_w, sr_latch_w, oe_w, busy_w;
  logic [15:0] cnt_w [2];

  int n_chk  = 0;
  int n_fail = 0;

  logic [47:0] exp_log[$];
  int          base = 0;

  relay_shift_driver #(.WIDTH(48), .CLK_DIV(4)) dut_slow (
    .clk(clk), .reset(reset), .relay_word(word),
    .sr_clk(sr_clk_w[0]), .sr_data(sr_data_w[0]), .sr_latch(sr_latch_w[0]),
    .sr_oe_n(oe_w[0]), .busy(busy_w[0]), .xfer_count(cnt_w[0])
  );

  relay_shift_driver #(.WIDTH(48), .CLK_DIV(1)) dut_fast (
    .clk(clk), .reset(reset), .relay_word(word),
    .sr_clk(sr_clk_w[1]), .sr_data(sr_data_w[1]), .sr_latch(sr_latch_w[1]),
    .sr_oe_n(oe_w[1]), .busy(busy_w[1]), .xfer_count(cnt_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int DIV      = (g == 0) ? 4 : 1;
    localparam int BUSY_EXP = 1 + 2 * 48 * DIV + DIV;
    logic [47:0] cap;
    int          nb, rd, lat_w, busy_len, viol;
    logic        p_clk, p_data, p_latch, p_busy, latched;

    always @(negedge clk) begin
      if (reset) begin
        cap = '0; nb = 0; rd = base; lat_w = 0; busy_len = 0; viol = 0; latched = 1'b0;
      end else begin
        if (sr_clk_w[g] && !p_clk) begin
          cap = {cap[46:0], sr_data_w[g]};
          nb++;
        end
        if (sr_clk_w[g] && p_clk && (sr_data_w[g] !== p_data)) viol++;
        if (sr_latch_w[g] && sr_clk_w[g]) viol++;
        if (sr_latch_w[g] && !p_latch) begin
          check($sformatf("nbits%0d", g), 64'(nb), 64'd48);
          if (rd < exp_log.size()) check($sformatf("word%0d", g), 64'(cap), 64'(exp_log[rd]));
          else check($sformatf("extra_xfer%0d", g), 64'(rd), 64'(exp_log.size()));
          check($sformatf("proto%0d", g), 64'(viol), 64'd0);
          rd++;
          nb = 0;
        end
        if (sr_latch_w[g]) lat_w++;
        else if (p_latch) begin
          check($sformatf("latch_w%0d", g), 64'(lat_w), 64'(DIV));
          lat_w = 0;
          latched = 1'b1;
        end
        if (!oe_w[g] && !latched) viol++;
        if (busy_w[g]) busy_len++;
        else if (p_busy) begin
          check($sformatf("busy_len%0d", g), 64'(busy_len), 64'(BUSY_EXP));
          busy_len = 0;
        end
      end
      p_clk   = sr_clk_w[g];
      p_data  = sr_data_w[g];
      p_latch = sr_latch_w[g];
      p_busy  = busy_w[g];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 8 && n < 5000) begin
      tick();
      n++;
      if (busy_w == 2'b00) quiet++;
      else quiet = 0;
    end
    if (quiet < 8) check("idle_timeout", 64'(quiet), 64'd8);
  endtask

  task automatic check_counts(input string tag, input int exp_cnt);
    check({tag, "_cnt0"}, 64'(cnt_w[0]), 64'(exp_cnt));
    check({tag, "_cnt1"}, 64'(cnt_w[1]), 64'(exp_cnt));
    check({tag, "_drain0"}, 64'(mon[0].rd), 64'(exp_log.size()));
    check({tag, "_drain1"}, 64'(mon[1].rd), 64'(exp_log.size()));
  endtask

  initial begin
    int n;
    logic [47:0] glitch;

    reset = 1'b1;
    word  = 48'h0000_0000_0001;
    base  = 0;
    exp_log.push_back(word);
    repeat (3) tick();
    check("rst_out0", 64'({sr_clk_w[0], sr_data_w[0], sr_latch_w[0], oe_w[0], busy_w[0]}), 64'(5'b00010));
    check("rst_cnt0", 64'(cnt_w[0]), 64'd0);

    // First transfer after reset release.
    reset = 1'b0;
    n = 0;
    while (!busy_w[0] && n < 20) begin
      tick();
      n++;
    end
    check("start_latency", 64'(n <= 4), 64'd1);
    wait_idle();
    check("oe_after_first", 64'(oe_w), 64'(2'b00));
    check_counts("t1", 1);

    // Idle word change.
    word = 48'h8300_0000_0001;
    exp_log.push_back(word);
    wait_idle();
    check_counts("t2", 2);

    // Change in the middle of a transfer.
    word = 48'h1234_5678_9ABC;
    exp_log.push_back(word);
    n = 0;
    while (mon[0].nb != 10 && n < 2000) begin
      tick();
      n++;
    end
    check("reach_bit10", 64'(mon[0].nb), 64'd10);
    word = 48'hAAAA_AAAA_AAAA;
    exp_log.push_back(word);
    n = 0;
    while (busy_w[0] && n < 2000) begin
      tick();
      n++;
    end
    n = 0;
    while (!busy_w[0] && n < 20) begin
      tick();
      n++;
    end
    check("restart_gap", 64'(n), 64'd1);
    wait_idle();
    check_counts("t3", 4);

    // One-cycle glitch while idle.
    glitch = 48'h5555_0000_FFFF;
    word = glitch;
    tick();
    word = 48'hAAAA_AAAA_AAAA;
    n = 0;
    repeat (30) begin
      tick();
      if (busy_w != 2'b00) n++;
    end
    check("glitch_busy", 64'(n), 64'd0);
    check_counts("t4", 4);

    // Reset during the high phase of bit 20.
    word = 48'h0F0F_0F0F_0F0F;
    exp_log.push_back(word);
    n = 0;
    while (!(mon[0].nb == 21 && sr_clk_w[0]) && n < 2000) begin
      tick();
      n++;
    end
    check("reach_bit20", 64'({busy_w[0], sr_clk_w[0]}), 64'(2'b11));
    reset = 1'b1;
    base  = exp_log.size();
    exp_log.push_back(word);
    #1;
    check("abort_out0", 64'({sr_clk_w[0], sr_data_w[0], sr_latch_w[0], oe_w[0], busy_w[0]}), 64'(5'b00010));
    check("abort_cnt0", 64'(cnt_w[0]), 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    wait_idle();
    check("oe_after_abort", 64'(oe_w), 64'(2'b00));
    check_counts("t5", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
